// File: rtl/fb_pkg.sv
// Shared framebuffer window geometry, command opcodes and writer FSM encoding.
// Used by both the pixel writer and the display reader.
package fb_pkg;

  localparam int unsigned FB_WIDTH   = 488;
  localparam int unsigned FB_HEIGHT  = 280;
  localparam int unsigned WST        = 76;
  localparam int unsigned HST        = 100;
  localparam int unsigned START_ADDR = 0;
  localparam int unsigned FB_WORDS   = 17080;

  localparam logic OP_PIXEL = 1'b0;
  localparam logic OP_FILL  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FILL = 2'd3
  } state_t;

endpackage

// File: rtl/fb_addr_calc.sv
// Maps absolute screen (x, y) to screen-RAM word address, nibble lane and window hit.
module fb_addr_calc
  import fb_pkg::*;
#(
  parameter int unsigned SCREEN_WIDTH = 11,
  parameter int unsigned ADDR_WIDTH   = 25
) (
  input  logic [SCREEN_WIDTH-1:0] x,
  input  logic [SCREEN_WIDTH-1:0] y,
  output logic [ADDR_WIDTH-1:0]   word_addr,
  output logic [2:0]              lane,
  output logic                    in_window
);

  // Wide enough for FB_WIDTH*FB_HEIGHT without truncation.
  localparam int unsigned P_W = 20;

  logic [SCREEN_WIDTH-1:0] dx;
  logic [SCREEN_WIDTH-1:0] dy;
  logic [P_W-1:0]          p;

  assign in_window = (x >= SCREEN_WIDTH'(WST)) && (x < SCREEN_WIDTH'(WST + FB_WIDTH)) &&
                     (y >= SCREEN_WIDTH'(HST)) && (y < SCREEN_WIDTH'(HST + FB_HEIGHT));

  assign dx = x - SCREEN_WIDTH'(WST);
  assign dy = y - SCREEN_WIDTH'(HST);
  assign p  = P_W'(dy) * P_W'(FB_WIDTH) + P_W'(dx);

  assign word_addr = ADDR_WIDTH'(START_ADDR) + ADDR_WIDTH'(p >> 3);
  assign lane      = p[2:0];

endmodule

// File: rtl/fb_pixel_writer.sv
// CPU-side framebuffer writer: read-modify-write of single pixels and full-window fill
// into the 32-bit-word screen RAM, using the display stage's nibble packing.
module fb_pixel_writer
  import fb_pkg::*;
#(
  parameter int unsigned SCREEN_WIDTH = 11,
  parameter int unsigned ADDR_WIDTH   = 25,
  parameter int unsigned DATA_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_op,
  input  logic [SCREEN_WIDTH-1:0] req_x,
  input  logic [SCREEN_WIDTH-1:0] req_y,
  input  logic [3:0]              req_color,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic                    ram_re,
  input  logic [DATA_WIDTH-1:0]   ram_rdata,
  output logic                    ram_we,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  output logic                    done,
  output logic                    err_oob
);

  localparam int unsigned CNT_W   = 15;
  localparam int unsigned NIBBLES = DATA_WIDTH / 4;

  state_t                 state;
  state_t                 state_next;
  logic [CNT_W-1:0]       cnt;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [2:0]             lane_q;
  logic [3:0]             color_q;
  logic                   err_q;

  logic [ADDR_WIDTH-1:0]  calc_addr;
  logic [2:0]             calc_lane;
  logic                   calc_in_window;
  logic                   accept_pixel;
  logic                   accept_fill;
  logic                   reject_pixel;
  logic                   last_word;

  fb_addr_calc #(
    .SCREEN_WIDTH (SCREEN_WIDTH),
    .ADDR_WIDTH   (ADDR_WIDTH)
  ) u_addr_calc (
    .x         (req_x),
    .y         (req_y),
    .word_addr (calc_addr),
    .lane      (calc_lane),
    .in_window (calc_in_window)
  );

  assign last_word = (cnt == CNT_W'(FB_WORDS - 1));
  assign err_oob   = err_q;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next state and RAM-side outputs, decoded from the state register and latches only.
  always_comb begin
    state_next   = state;
    req_ready    = 1'b0;
    ram_re       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = '0;
    ram_wdata    = '0;
    done         = 1'b0;
    accept_pixel = 1'b0;
    accept_fill  = 1'b0;
    reject_pixel = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_op == OP_FILL) begin
            accept_fill = 1'b1;
            state_next  = ST_FILL;
          end else if (calc_in_window) begin
            accept_pixel = 1'b1;
            state_next   = ST_RD;
          end else begin
            reject_pixel = 1'b1;
          end
        end
      end
      ST_RD: begin
        ram_re     = 1'b1;
        ram_addr   = addr_q;
        state_next = ST_WR;
      end
      ST_WR: begin
        ram_we    = 1'b1;
        ram_addr  = addr_q;
        ram_wdata = ram_rdata;
        ram_wdata[{lane_q, 2'b00} +: 4] = color_q;
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      ST_FILL: begin
        ram_we    = 1'b1;
        ram_addr  = ADDR_WIDTH'(START_ADDR) + ADDR_WIDTH'(cnt);
        ram_wdata = {NIBBLES{color_q}};
        if (last_word) begin
          done       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Command latches, fill counter and the out-of-window pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      addr_q  <= '0;
      lane_q  <= '0;
      color_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= reject_pixel;
      if (accept_pixel) begin
        addr_q  <= calc_addr;
        lane_q  <= calc_lane;
        color_q <= req_color;
      end
      if (accept_fill) begin
        color_q <= req_color;
        cnt     <= '0;
      end else if (state == ST_FILL) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed self-checking bench for fb_pixel_writer with a one-cycle-latency RAM model.
module tb_fb_pixel_writer;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_op;
  logic [10:0] req_x;
  logic [10:0] req_y;
  logic [3:0]  req_color;
  logic [24:0] ram_addr;
  logic        ram_re;
  logic [31:0] ram_rdata;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic        done;
  logic        err_oob;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:32767];
  logic        poke_en;
  logic [14:0] poke_addr;
  logic [31:0] poke_data;

  fb_pixel_writer dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_color (req_color),
    .ram_addr  (ram_addr),
    .ram_re    (ram_re),
    .ram_rdata (ram_rdata),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .done      (done),
    .err_oob   (err_oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Screen RAM: registered read, write on strobe; bench preload has priority.
  always @(posedge clk) begin
    if (poke_en)     mem[poke_addr] <= poke_data;
    else if (ram_we) mem[ram_addr[14:0]] <= ram_wdata;
    if (ram_re)      ram_rdata <= mem[ram_addr[14:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [14:0] a, input logic [31:0] d);
    poke_addr = a;
    poke_data = d;
    poke_en   = 1'b1;
    tick();
    poke_en   = 1'b0;
  endtask

  task automatic pixel_write(input string tag, input int x, input int y, input logic [3:0] c,
                             input logic [31:0] exp_addr, input logic [31:0] exp_data);
    req_x = 11'(x); req_y = 11'(y); req_color = c; req_op = 1'b0; req_valid = 1'b1;
    check({tag, ".ready0"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check({tag, ".rd_re"}, 32'(ram_re), 32'd1);
    check({tag, ".rd_addr"}, 32'(ram_addr), exp_addr);
    check({tag, ".rd_we"}, 32'(ram_we), 32'd0);
    check({tag, ".rd_ready"}, 32'(req_ready), 32'd0);
    tick();
    check({tag, ".wr_we"}, 32'(ram_we), 32'd1);
    check({tag, ".wr_addr"}, 32'(ram_addr), exp_addr);
    check({tag, ".wr_data"}, ram_wdata, exp_data);
    check({tag, ".wr_done"}, 32'(done), 32'd1);
    tick();
    check({tag, ".ready3"}, 32'(req_ready), 32'd1);
    check({tag, ".done3"}, 32'(done), 32'd0);
    check({tag, ".mem"}, mem[exp_addr[14:0]], exp_data);
  endtask

  task automatic pixel_oob(input string tag, input int x, input int y);
    req_x = 11'(x); req_y = 11'(y); req_color = 4'h7; req_op = 1'b0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check({tag, ".err"}, 32'(err_oob), 32'd1);
    check({tag, ".re"}, 32'(ram_re), 32'd0);
    check({tag, ".we"}, 32'(ram_we), 32'd0);
    check({tag, ".ready"}, 32'(req_ready), 32'd1);
    tick();
    check({tag, ".err_clr"}, 32'(err_oob), 32'd0);
    check({tag, ".re2"}, 32'(ram_re), 32'd0);
  endtask

  initial begin
    int bad;
    int done_cnt;
    int we_cnt;

    rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_x = '0; req_y = '0; req_color = '0;
    poke_en = 1'b0; poke_addr = '0; poke_data = '0;
    repeat (2) tick();
    // A fill request held during reset must be ignored.
    req_valid = 1'b1; req_op = 1'b1; req_color = 4'h9;
    tick();
    req_valid = 1'b0; req_op = 1'b0;
    rst = 1'b0;
    check("rst.ready", 32'(req_ready), 32'd1);
    check("rst.re", 32'(ram_re), 32'd0);
    check("rst.we", 32'(ram_we), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.err", 32'(err_oob), 32'd0);
    check("rst.addr", 32'(ram_addr), 32'd0);
    check("rst.wdata", ram_wdata, 32'd0);
    tick();
    check("rst.idle_we", 32'(ram_we), 32'd0);
    check("rst.idle_ready", 32'(req_ready), 32'd1);

    // Pixel writes, lane and address decode.
    poke(15'd0, 32'h1234_5678);
    pixel_write("px76_100", 76, 100, 4'hA, 32'd0, 32'h1234_567A);
    poke(15'd0, 32'h0);
    pixel_write("px83_100", 83, 100, 4'h5, 32'd0, 32'h5000_0000);
    poke(15'd62, 32'h0000_00F0);
    pixel_write("px84_101", 84, 101, 4'hF, 32'd62, 32'h0000_00FF);
    poke(15'd17079, 32'h0);
    pixel_write("px_corner", 563, 379, 4'h1, 32'd17079, 32'h1000_0000);
    // Same word again right away: must see the previous write.
    pixel_write("px_coh", 77, 100, 4'h2, 32'd0, 32'h5000_0020);

    // Out-of-window pixels.
    pixel_oob("oob_x", 75, 100);
    pixel_oob("oob_y", 76, 380);
    pixel_oob("oob_x_hi", 564, 200);

    // Full-window fill.
    req_op = 1'b1; req_color = 4'h3; req_valid = 1'b1;
    check("fill.ready0", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0; req_op = 1'b0;
    bad = 0; done_cnt = 0;
    for (int i = 0; i < 17080; i++) begin
      if (ram_we !== 1'b1 || ram_addr !== 25'(i) || ram_wdata !== 32'h3333_3333 ||
          req_ready !== 1'b0 || ram_re !== 1'b0) bad++;
      if (done === 1'b1) begin
        done_cnt++;
        if (i != 17079) bad++;
      end
      tick();
    end
    check("fill.bad_cycles", 32'(bad), 32'd0);
    check("fill.done_count", 32'(done_cnt), 32'd1);
    check("fill.ready_end", 32'(req_ready), 32'd1);
    check("fill.we_end", 32'(ram_we), 32'd0);
    check("fill.done_end", 32'(done), 32'd0);
    check("fill.mem0", mem[0], 32'h3333_3333);
    check("fill.mem_mid", mem[8540], 32'h3333_3333);
    check("fill.mem_last", mem[17079], 32'h3333_3333);

    // Reset in the middle of a fill.
    req_op = 1'b1; req_color = 4'h6; req_valid = 1'b1;
    tick();
    req_valid = 1'b0; req_op = 1'b0;
    repeat (100) tick();
    check("abort.addr100", 32'(ram_addr), 32'd100);
    check("abort.we100", 32'(ram_we), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort.ready", 32'(req_ready), 32'd1);
    check("abort.we", 32'(ram_we), 32'd0);
    we_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ram_we === 1'b1 || ram_re === 1'b1) we_cnt++;
    end
    check("abort.no_strobes", 32'(we_cnt), 32'd0);
    check("abort.mem99", mem[99], 32'h6666_6666);
    check("abort.mem101", mem[101], 32'h3333_3333);
    pixel_write("post_abort", 76, 100, 4'hC, 32'd0, 32'h6666_666C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_pixel_writer.md
# fb_pixel_writer

Write-side companion of the VGA framebuffer reader: accepts pixel-write and window-fill commands from the CPU MMIO path and stores 4-bit colour IDs into the 32-bit-word screen RAM. It uses exactly the packing the display stage decodes, so a written pixel appears on screen at the same (x, y). It sits between the MMIO decoder and the write port of the dual-port screen RAM; the display stage owns the other port.

## Interface
- SCREEN_WIDTH, 11, width of x/y coordinates
- ADDR_WIDTH, 25, RAM word-address width
- DATA_WIDTH, 32, RAM word width (8 pixels × 4 bits)
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  command valid
- req_ready  out  1  block can accept; high exactly when FSM is IDLE
- req_op  in  1  0 = pixel write, 1 = fill whole window
- req_x, req_y  in  SCREEN_WIDTH  absolute screen coordinates (ignored for fill)
- req_color  in  4  colour ID
- ram_addr  out  ADDR_WIDTH  word address
- ram_re  out  1  read strobe; data is valid on ram_rdata one cycle later
- ram_rdata  in  DATA_WIDTH  read data
- ram_we  out  1  write strobe
- ram_wdata  out  DATA_WIDTH  write data
- done  out  1  one-cycle pulse when an accepted command finishes its last RAM write
- err_oob  out  1  one-cycle pulse when a pixel command falls outside the window

## Operation
- Window constants: FB_WIDTH=488, FB_HEIGHT=280, WST=76, HST=100, START_ADDR=0, FB_WORDS=17080.
- In-window test (unsigned): WST ≤ x < WST+FB_WIDTH and HST ≤ y < HST+FB_HEIGHT.
- Pixel index p = (y−HST)·FB_WIDTH + (x−WST), computed in 18+ bits with no truncation.
- Word address = START_ADDR + (p >> 3). Lane = p[2:0]. The nibble occupies bits [4·lane+3 : 4·lane].
- Equivalently, lane = (x[2:0] − 4) mod 8, which matches the display decode.
- FSM states: IDLE, RD, WR, FILL.
- IDLE: req_ready=1. On req_valid with req_op=0 and in window, latch word address, lane and colour, then go to RD. If the pixel is out of window, drop it, pulse err_oob next cycle, and stay IDLE. On req_valid with req_op=1, latch colour, clear the fill counter, and go to FILL.
- RD: ram_re=1, ram_addr=latched word. Next state is WR.
- WR: ram_we=1, same address. ram_wdata = ram_rdata with the selected nibble replaced by colour; other nibbles are unchanged. done=1. Next state is IDLE.
- FILL: ram_we=1, ram_addr=START_ADDR+cnt, ram_wdata = colour replicated ×8. cnt increments each cycle. When cnt = FB_WORDS−1, done=1 and the next state is IDLE.
- Commands presented while not IDLE are not accepted; the master holds them.
- Reset: state=IDLE, cnt=0, all latches 0. ram_re, ram_we, done and err_oob are 0. ram_addr and ram_wdata are 0. req_ready=1 from the first cycle after reset.
- req_valid is ignored in any cycle with rst=1.
- Reset mid-command aborts it; no further RAM strobes follow.

## Timing
- Pixel write, with accept at cycle 0: read at cycle 1, write plus done at cycle 2, req_ready high again at cycle 3. Throughput is one pixel per 3 cycles.
- Back-to-back writes to the same word are coherent: the write at cycle 2 precedes the next read at cycle ≥4.
- Out-of-window pixel: err_oob at cycle 1, no RAM strobes, ready stays high.
- Fill: writes on cycles 1…17080, done on cycle 17080, ready high on cycle 17081.
- All outputs are registered or decoded from the state register; there is no combinational path from req_* to ram_*.

## Structure
- Shared package/header fb_pkg holds:
  - FB_WIDTH, FB_HEIGHT, WST, HST, START_ADDR, FB_WORDS
  - OP_PIXEL/OP_FILL encodings
  - FSM state encoding
- The display reader also uses these constants.
- Sub-module fb_addr_calc (combinational): (x, y) → word address, lane, in_window. It is a natural shared unit with the display side.

## Test plan
- Reset; RAM[0]=0x12345678; pixel (76,100) colour 0xA → RAM read 0 at cycle 1; write addr 0, data 0x1234567A, done at cycle 2.
- RAM[0]=0; pixel (83,100) colour 0x5 → write addr 0, data 0x50000000.
- RAM[62]=0x000000F0; pixel (84,101) colour 0xF → write addr 62, data 0x000000FF.
- Corner pixel (563,379) colour 0x1 over 0 → write addr 17079, data 0x10000000.
- Pixel (75,100) and pixel (76,380) → no ram_re/ram_we; err_oob pulse each; ready back immediately.
- Fill colour 0x3 → 17080 consecutive writes, addr 0…17079, data 0x33333333; ready low throughout; single done on last.
- Assert rst during fill at word 100 → no write after the reset cycle; ready=1. A following pixel write completes normally.
